e_mdu: RTL
==========

Name: e_mdu

Overview:
Multiply/divide unit in the EX stage, running beside the ALU. It executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers. It serves mfhi/mflo reads and mthi/mtlo writes. It exports Busy, and the hazard unit combines Start|Busy to stall MDU-class instructions in D.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high after a mult/multu start
DIV_CYCLES, 10, cycles Busy stays high after a div/divu start

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
A  input  32  operand rs (forwarded value)
B  input  32  operand rt (forwarded value)
MDUOp  input  4  operation select, encodings from the shared definitions header
Start  input  1  EX-stage pulse: MDUOp is mult/multu/div/divu this cycle
Busy  output  1  high while an operation is in flight
HI  output  32  HI register, registered
LO  output  32  LO register, registered
C  output  32  combinational read: HI for mfhi, LO for mflo, else 0

Behaviour:
- Reset (clk edge with reset=1): HI=0, LO=0, Busy=0, counter=0, pending results=0. This takes priority over all other inputs.
- Reset mid-operation: the in-flight result is discarded and Busy=0 on the next cycle. No late HI/LO write ever occurs.
- Start accept: Start=1 and Busy=0 at edge t.
  - Operands A and B are latched at edge t.
  - The 64-bit result is computed into a pending register (behavioural * / %// is allowed).
  - counter loads MULT_CYCLES or DIV_CYCLES; Busy=1 from after edge t.
- In flight:
  - The counter decrements each edge.
  - At the edge where counter goes 1→0, HI/LO take the pending values and Busy falls.
  - Busy is high for exactly N cycles (N = latency); HI/LO update on the Nth edge after t.
- Start while Busy=1: ignored; the hazard unit guarantees this never happens. Start with a non-mult/div MDUOp: ignored.
- mult: signed 64-bit product {HI,LO}=A*B. multu: unsigned product.
- div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (B=0, div or divu): the full latency still elapses and HI/LO are unchanged at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo:
  - When MDUOp selects them and Busy=0, HI (or LO) takes A at the edge, with no Busy.
  - If Busy=1 the write is ignored; the hazard unit stalls these instructions.
- mfhi/mflo: C is combinational from the current HI/LO. Old values remain visible while Busy=1.
- Same-cycle mthi followed next cycle by mfhi: C returns the new value, since the register was already written.

Decomposition:
- The shared definitions header gets the MDUOp encodings: MDU_none=0, MDU_mult=1, MDU_multu=2, MDU_div=3, MDU_divu=4, MDU_mfhi=5, MDU_mflo=6, MDU_mthi=7, MDU_mtlo=8.
- The same header also holds the is-mult/is-div decode macros shared with the hazard unit.
- No sub-module: counter, pending registers and HI/LO are a single flat block.

Test Plan:
1. mult, A=0xFFFFFFFF, B=2, Start for 1 cycle:
   - Busy is high for exactly 5 cycles.
   - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
   - HI/LO hold their old values throughout Busy.
2. multu, same operands: after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
3. div:
   - A=0xFFFFFFF9 (-7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu 7/2 → LO=3, HI=1.
   - A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
4. Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then div by B=0. Busy lasts 10 cycles and HI=0x11, LO=0x22 afterwards.
5. Reset during busy: start a div, assert reset on cycle 4.
   - Busy=0 and HI=LO=0 next cycle.
   - No update when cycle 10 would have completed.
6. mthi A=0xDEADBEEF, then mfhi next cycle → C=0xDEADBEEF.
   - mtlo issued while Busy=1 → LO is unchanged.
   - Start pulse while Busy=1 → counter is not reloaded.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation encodings and mult/div class decode
// used by both the MDU and the hazard unit.
package e_mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;
    localparam int unsigned XLEN     = 32;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    function automatic logic is_mult(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// EX-stage multiply/divide unit: fixed-latency mult/div into HI/LO,
// plus mthi/mtlo writes and combinational mfhi/mflo reads.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     A,
    input  logic [XLEN-1:0]     B,
    input  logic [MDU_OP_W-1:0] MDUOp,
    input  logic                Start,
    output logic                Busy,
    output logic [XLEN-1:0]     HI,
    output logic [XLEN-1:0]     LO,
    output logic [XLEN-1:0]     C
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    pend_hi;
    logic [XLEN-1:0]    pend_lo;
    logic               pend_wr;

    logic [2*XLEN-1:0]  prod_s;
    logic [2*XLEN-1:0]  prod_u;
    logic [XLEN-1:0]    res_hi;
    logic [XLEN-1:0]    res_lo;
    logic               res_wr;

    assign prod_s = $signed({{XLEN{A[XLEN-1]}}, A}) * $signed({{XLEN{B[XLEN-1]}}, B});
    assign prod_u = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};

    // Result computed at accept; divide by zero suppresses the final write.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b1;
        case (MDUOp)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (B == '0) begin
                    res_wr = 1'b0;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    res_lo = A;
                    res_hi = '0;
                end else begin
                    res_lo = XLEN'($signed(A) / $signed(B));
                    res_hi = XLEN'($signed(A) % $signed(B));
                end
            end
            MDU_DIVU: begin
                if (B == '0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Busy    <= 1'b0;
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (Busy) begin
            // Start and mthi/mtlo are ignored while an operation is in flight.
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                Busy <= 1'b0;
                if (pend_wr) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
        end else if (Start && (is_mult(MDUOp) || is_div(MDUOp))) begin
            Busy    <= 1'b1;
            cnt     <= is_mult(MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
        end else if (MDUOp == MDU_MTHI) begin
            HI <= A;
        end else if (MDUOp == MDU_MTLO) begin
            LO <= A;
        end
    end

    always_comb begin
        C = '0;
        if (MDUOp == MDU_MFHI) C = HI;
        else if (MDUOp == MDU_MFLO) C = LO;
    end

endmodule
